// File: rtl/alarm_ctrl.sv
// Time-of-day keeper with button-driven time/alarm setting and a self-cancelling alarm.
// All outputs are registered and respond one clock after the input pulse.
module alarm_ctrl #(
    parameter int RING_SECS = 60
) (
    input  logic       clk,
    input  logic       reset_sync,
    input  logic       sec_inc,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       alarm_off,
    output logic       sec_clr,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       alarm_en,
    output logic       alarm_ring,
    output logic [2:0] mode
);

    // state      | meaning
    // RUN        | normal timekeeping; btn_up toggles alarm_en; alarm may trigger
    // SET_HR     | btn_up advances hours; seconds held at 0, counter cleared
    // SET_MIN    | btn_up advances minutes; seconds held at 0, counter cleared
    // SET_AL_HR  | btn_up advances alarm_hours; time keeps running
    // SET_AL_MIN | btn_up advances alarm_minutes; time keeps running
    typedef enum logic [2:0] {
        RUN        = 3'd0,
        SET_HR     = 3'd1,
        SET_MIN    = 3'd2,
        SET_AL_HR  = 3'd3,
        SET_AL_MIN = 3'd4
    } mode_t;

    localparam logic [5:0] RING_LOAD = 6'(RING_SECS);

    mode_t      state, state_nxt;
    logic [5:0] ring_cnt;

    logic       up_ok;
    logic       timekeep;
    logic       trigger;
    logic       ring_cancel;
    logic [4:0] tk_hr;
    logic [5:0] tk_min;
    logic [5:0] tk_sec;

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:        if (btn_mode) state_nxt = SET_HR;
            SET_HR:     if (btn_mode) state_nxt = SET_MIN;
            SET_MIN:    if (btn_mode) state_nxt = SET_AL_HR;
            SET_AL_HR:  if (btn_mode) state_nxt = SET_AL_MIN;
            SET_AL_MIN: if (btn_mode) state_nxt = RUN;
            default:    state_nxt = RUN;
        endcase
    end

    assign mode = state;

    // A mode press swallows a coincident up press.
    assign up_ok    = btn_up && !btn_mode;
    assign timekeep = sec_inc && (state == RUN || state == SET_AL_HR || state == SET_AL_MIN);

    always_comb begin
        tk_hr  = hours;
        tk_min = minutes;
        tk_sec = seconds;
        if (seconds == 6'd59) begin
            tk_sec = 6'd0;
            if (minutes == 6'd59) begin
                tk_min = 6'd0;
                tk_hr  = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
            end else begin
                tk_min = minutes + 6'd1;
            end
        end else begin
            tk_sec = seconds + 6'd1;
        end
    end

    // Trigger looks at the pre-toggle alarm_en; a toggle to 0 in the same cycle cancels.
    assign trigger = timekeep && (state == RUN) && alarm_en && (tk_sec == 6'd0)
                     && (tk_hr == alarm_hours) && (tk_min == alarm_minutes);

    assign ring_cancel = alarm_off || btn_mode || ((state == RUN) && up_ok && alarm_en);

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            hours   <= 5'd0;
            minutes <= 6'd0;
            seconds <= 6'd0;
        end else begin
            if (timekeep) begin
                hours   <= tk_hr;
                minutes <= tk_min;
                seconds <= tk_sec;
            end
            if (state == SET_HR && up_ok) begin
                hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
            end
            if (state == SET_MIN && up_ok) begin
                minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
            end
            if (state_nxt == SET_HR || state_nxt == SET_MIN) begin
                seconds <= 6'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            alarm_hours   <= 5'd0;
            alarm_minutes <= 6'd0;
            alarm_en      <= 1'b0;
            sec_clr       <= 1'b0;
        end else begin
            if (state == SET_AL_HR && up_ok) begin
                alarm_hours <= (alarm_hours == 5'd23) ? 5'd0 : alarm_hours + 5'd1;
            end
            if (state == SET_AL_MIN && up_ok) begin
                alarm_minutes <= (alarm_minutes == 6'd59) ? 6'd0 : alarm_minutes + 6'd1;
            end
            if (state == RUN && up_ok) begin
                alarm_en <= !alarm_en;
            end
            sec_clr <= (state_nxt == SET_HR) || (state_nxt == SET_MIN);
        end
    end

    // Ring timer counts down on sec_inc; terminal count ends the ring.
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            alarm_ring <= 1'b0;
            ring_cnt   <= 6'd0;
        end else if (ring_cancel) begin
            alarm_ring <= 1'b0;
            ring_cnt   <= 6'd0;
        end else if (trigger) begin
            alarm_ring <= 1'b1;
            ring_cnt   <= RING_LOAD;
        end else if (alarm_ring && sec_inc) begin
            if (ring_cnt <= 6'd1) begin
                alarm_ring <= 1'b0;
                ring_cnt   <= 6'd0;
            end else begin
                ring_cnt <= ring_cnt - 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: set modes, rollover, alarm fire/timeout, cancels, collisions, reset.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset_sync = 1'b1;
    logic       sec_inc = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       alarm_off = 1'b0;
    logic       sec_clr;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       alarm_en;
    logic       alarm_ring;
    logic [2:0] mode;

    int tests = 0;
    int failed = 0;

    alarm_ctrl #(.RING_SECS(60)) dut (
        .clk(clk),
        .reset_sync(reset_sync),
        .sec_inc(sec_inc),
        .btn_mode(btn_mode),
        .btn_up(btn_up),
        .alarm_off(alarm_off),
        .sec_clr(sec_clr),
        .hours(hours),
        .minutes(minutes),
        .seconds(seconds),
        .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm_en(alarm_en),
        .alarm_ring(alarm_ring),
        .mode(mode)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic m, input logic u, input logic o, input logic s, input logic r);
        @(negedge clk);
        btn_mode   = m;
        btn_up     = u;
        alarm_off  = o;
        sec_inc    = s;
        reset_sync = r;
        @(posedge clk);
        #1;
        btn_mode   = 1'b0;
        btn_up     = 1'b0;
        alarm_off  = 1'b0;
        sec_inc    = 1'b0;
        reset_sync = 1'b0;
    endtask

    task automatic press_mode(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, "_hr"}, 32'(hours), h);
        chk({tag, "_min"}, 32'(minutes), m);
        chk({tag, "_sec"}, 32'(seconds), s);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mode"}, 32'(mode), 0);
        chk_time(tag, 0, 0, 0);
        chk({tag, "_al_hr"}, 32'(alarm_hours), 0);
        chk({tag, "_al_min"}, 32'(alarm_minutes), 0);
        chk({tag, "_en"}, 32'(alarm_en), 0);
        chk({tag, "_ring"}, 32'(alarm_ring), 0);
        chk({tag, "_sec_clr"}, 32'(sec_clr), 0);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Set time
        press_mode(1);
        chk("enter_sethr_mode", 32'(mode), 1);
        chk("enter_sethr_clr", 32'(sec_clr), 1);
        chk("enter_sethr_sec", 32'(seconds), 0);
        press_up(5);
        chk("set_hr5", 32'(hours), 5);
        secs(1);
        chk("sethr_sec_hold", 32'(seconds), 0);
        press_mode(1);
        chk("setmin_mode", 32'(mode), 2);
        chk("setmin_clr", 32'(sec_clr), 1);
        press_up(61);
        chk("setmin_wrap", 32'(minutes), 1);
        chk("setmin_no_carry", 32'(hours), 5);
        secs(3);
        chk("setmin_sec_hold", 32'(seconds), 0);
        press_mode(1);
        chk("setalhr_mode", 32'(mode), 3);
        chk("setalhr_clr", 32'(sec_clr), 0);

        // mode + up collision in SET_HR
        press_mode(3);
        chk("back_to_sethr", 32'(mode), 1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("coll_mode", 32'(mode), 2);
        chk("coll_hr", 32'(hours), 5);

        // Force 23:59:58 and roll over
        press_up(58);
        press_mode(4);
        press_up(18);
        press_mode(4);
        chk("run_after_set", 32'(mode), 0);
        chk_time("set2359", 23, 59, 0);
        secs(58);
        chk_time("t235958", 23, 59, 58);
        secs(1);
        chk_time("t235959", 23, 59, 59);
        chk("t235959_mode", 32'(mode), 0);
        secs(1);
        chk_time("t000000", 0, 0, 0);
        chk("t000000_mode", 32'(mode), 0);
        chk("disabled_no_ring", 32'(alarm_ring), 0);

        // Alarm at 00:01, fire and time out
        press_mode(4);
        press_up(1);
        press_mode(1);
        chk("al_min1", 32'(alarm_minutes), 1);
        chk("al_hr0", 32'(alarm_hours), 0);
        press_up(1);
        chk("en_on", 32'(alarm_en), 1);
        secs(59);
        chk_time("t000059", 0, 0, 59);
        chk("pre_trigger", 32'(alarm_ring), 0);
        secs(1);
        chk_time("t000100", 0, 1, 0);
        chk("ring_rise", 32'(alarm_ring), 1);
        secs(59);
        chk("ring_hold59", 32'(alarm_ring), 1);
        secs(1);
        chk_time("t000200", 0, 2, 0);
        chk("ring_timeout", 32'(alarm_ring), 0);

        // Cancel with alarm_off
        press_mode(4);
        press_up(2);
        press_mode(1);
        secs(60);
        chk("ring_0003", 32'(alarm_ring), 1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("off_cancel", 32'(alarm_ring), 0);
        chk("off_mode", 32'(mode), 0);

        // Cancel with btn_mode
        press_mode(4);
        press_up(1);
        press_mode(1);
        secs(60);
        chk("ring_0004", 32'(alarm_ring), 1);
        press_mode(1);
        chk("mode_cancel", 32'(alarm_ring), 0);
        chk("mode_cancel_mode", 32'(mode), 1);

        // Cancel with btn_up in RUN
        press_mode(3);
        press_up(1);
        press_mode(1);
        secs(60);
        chk_time("t000500", 0, 5, 0);
        chk("ring_0005", 32'(alarm_ring), 1);
        press_up(1);
        chk("up_cancel_en", 32'(alarm_en), 0);
        chk("up_cancel_ring", 32'(alarm_ring), 0);

        // alarm_off on the trigger cycle
        press_up(1);
        press_mode(4);
        press_up(1);
        press_mode(1);
        secs(59);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_time("t000600", 0, 6, 0);
        chk("off_at_trigger", 32'(alarm_ring), 0);
        chk("off_at_trigger_en", 32'(alarm_en), 1);

        // Reset while ringing
        press_mode(4);
        press_up(1);
        press_mode(1);
        secs(60);
        chk("ring_0007", 32'(alarm_ring), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_reset("rst_ring");

        // Reset in SET_MIN
        press_mode(2);
        press_up(1);
        chk("setmin2_mode", 32'(mode), 2);
        chk("setmin2_min", 32'(minutes), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_reset("rst_setmin");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Time-of-day and alarm controller for the alarm clock. It consumes the one-cycle `sec_inc` pulse from the 50 MHz seconds counter and keeps hours, minutes and seconds. It drives `sec_clr` to hold that counter cleared while the user sets the time. A button-driven state machine sequences time-set and alarm-set modes, and the block raises `alarm_ring` when the running time reaches the enabled alarm time.

## Interface
Parameters:
- `RING_SECS`, default 60: number of `sec_inc` pulses the alarm rings before self-cancelling (1..63).

Ports:
- `clk` input 1: system clock, 50 MHz.
- `reset_sync` input 1: reset, synchronous to `clk`, active-high.
- `sec_inc` input 1: one-cycle pulse from the seconds counter, once per second.
- `btn_mode` input 1: debounced single-cycle pulse; advances the mode.
- `btn_up` input 1: debounced single-cycle pulse; increments the selected field, or toggles alarm enable in RUN.
- `alarm_off` input 1: single-cycle pulse; cancels ringing.
- `sec_clr` output 1: synchronous clear to the seconds counter; high while in SET_HR or SET_MIN.
- `hours` output 5: current hour, 0..23.
- `minutes` output 6: current minute, 0..59.
- `seconds` output 6: current second, 0..59.
- `alarm_hours` output 5: alarm hour, 0..23.
- `alarm_minutes` output 6: alarm minute, 0..59.
- `alarm_en` output 1: alarm armed.
- `alarm_ring` output 1: alarm sounding.
- `mode` output 3: state encoding: RUN=0, SET_HR=1, SET_MIN=2, SET_AL_HR=3, SET_AL_MIN=4.

## Operation
- **FSM cycle on `btn_mode`:** RUN → SET_HR → SET_MIN → SET_AL_HR → SET_AL_MIN → RUN. There are no other transitions. Encodings 5..7 return to RUN on the next clock.
- **Entering SET_HR:** `seconds` loads 0.
- **In SET_HR and SET_MIN:**
  - `sec_inc` is ignored and `seconds` holds 0.
  - `btn_up` increments `hours` (23→0) or `minutes` (59→0). There is no carry into `hours`.
- **In SET_AL_HR and SET_AL_MIN:**
  - `btn_up` increments `alarm_hours` (23→0) or `alarm_minutes` (59→0).
  - Timekeeping continues on `sec_inc`.
- **In RUN:** `btn_up` toggles `alarm_en`.
- **Timekeeping** (RUN, SET_AL_HR, SET_AL_MIN), on each `sec_inc`:
  - `seconds` increments, 59→0 with carry to `minutes`.
  - `minutes` 59→0 with carry to `hours`.
  - `hours` 23→0.
  - 23:59:59 + `sec_inc` = 00:00:00.
- **Trigger:** occurs on the `sec_inc` whose next-state time is HH:MM:00 with HH:MM equal to the alarm, `alarm_en`=1, and `mode`=RUN.
  - The trigger sets `alarm_ring` and loads `ring_cnt` = `RING_SECS`.
- **Ringing:** each later `sec_inc` decrements `ring_cnt`. When `ring_cnt` reaches 0, `alarm_ring` clears. Ring duration is therefore `RING_SECS` seconds.
- **Ring cancel:** any of the following clears `alarm_ring` and `ring_cnt` on the next clock:
  - `alarm_off`;
  - `btn_mode`;
  - `alarm_en` toggled to 0.
- **Simultaneous events:**
  - `btn_mode` together with `btn_up`: the mode change wins; `btn_up` is dropped.
  - `alarm_off` together with a trigger: no ring.
  - `sec_inc` together with `btn_up` in a SET_AL state: both take effect.
  - `btn_up` and a trigger in the same RUN cycle: the toggle applies and the trigger uses the pre-toggle `alarm_en`. If the toggle takes `alarm_en` to 0, the ring is cancelled.
- **Reset:**
  - `mode`=RUN; `hours`/`minutes`/`seconds`=0; `alarm_hours`/`alarm_minutes`=0.
  - `alarm_en`=0, `alarm_ring`=0, `sec_clr`=0, `ring_cnt`=0.
  - Reset overrides all inputs in the same cycle, including mid-ring and mid-set.

## Timing
- All outputs are registered. Every response appears on the first rising edge after the input pulse is sampled, i.e. 1-cycle latency.
- `sec_clr` is decoded from the registered state:
  - high from the edge that enters SET_HR;
  - low from the edge that leaves SET_MIN.
  - The seconds counter therefore restarts a full 1 s period from the RUN/SET_AL_HR entry.
- Inputs are assumed single-cycle pulses. A level held N cycles counts as N events; debouncing and edge detection are done upstream.
- `alarm_ring` rises on the same edge as the time rollover to HH:MM:00.

## Test plan
- **Rollover:** reset, force time 23:59:58 via set mode, return to RUN, give 2 `sec_inc` pulses → 23:59:59, then 00:00:00. `mode`=0 throughout.
- **Set time:**
  - `btn_mode` → `mode`=1 and `sec_clr`=1 next cycle; `seconds`=0.
  - 5×`btn_up` → `hours`=5.
  - `btn_mode`, 61×`btn_up` → `minutes`=1 (wrap at 59).
  - `sec_inc` pulses in these modes leave `seconds`=0.
  - `btn_mode` → `mode`=3 and `sec_clr`=0.
- **Alarm fire and timeout:**
  - Set alarm 00:01 with `alarm_en`=1, time 00:00:58, `RING_SECS`=60.
  - 2 `sec_inc` pulses → `alarm_ring`=1 on the edge where the time becomes 00:01:00.
  - 60 more pulses → `alarm_ring`=0 at 00:02:00.
- **Cancel paths:**
  - While ringing, `alarm_off` → `alarm_ring`=0 next cycle.
  - Repeat with `btn_mode` → `alarm_ring`=0 and `mode`=1.
  - Repeat with `btn_up` in RUN → `alarm_en`=0 and `alarm_ring`=0.
- **Collisions:**
  - `btn_mode`+`btn_up` same cycle in SET_HR → `mode`=2, `hours` unchanged.
  - `alarm_off` on the trigger cycle → `alarm_ring` stays 0.
  - Alarm disabled (`alarm_en`=0) at match → no ring.
- **Reset mid-operation:** assert `reset_sync` for 1 cycle while ringing in RUN and again while in SET_MIN → next cycle all outputs at reset values (`mode`=0, time 00:00:00, `sec_clr`=0, `alarm_ring`=0).
